asrv32_alu_md: RTL
==================

# asrv32_alu_md

Parametrised, registered execute-stage ALU for the asrv32 core, extending the base RV32I integer/compare operation set with the M-extension multiply, divide and remainder operations. Base operations complete in one cycle; multiply/divide run on a shared iterative radix-2 datapath under a valid/ready handshake. Sits between the decoder and the writeback stage in place of the single-cycle ALU.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64.
- SHW, $clog2(XLEN): shift-amount width. Derived, not overridden.
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  operation request; accepted on an edge where i_valid & o_ready & !i_flush.
- o_ready  out  1  block can accept a request this cycle.
- i_op  in  5  operation code, see Operation.
- i_op1  in  XLEN  operand 1 (rs1 or pc).
- i_op2  in  XLEN  operand 2 (rs2 or imm).
- i_flush  in  1  abort the in-flight operation (pipeline flush/trap).
- o_valid  out  1  one-cycle pulse: o_result holds a new result.
- o_result  out  XLEN  result; holds its value until the next o_valid.

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 XOR, 5 OR, 6 AND, 7 SLL, 8 SRL, 9 SRA, 10 EQ, 11 NEQ, 12 GE, 13 GEU, 14 MUL, 15 MULH, 16 MULHSU, 17 MULHU, 18 DIV, 19 DIVU, 20 REM, 21 REMU. Codes 22-31: accepted as base ops, result 0.
- Compare ops (2,3,10-13) return 0 or 1 zero-extended to XLEN. SLT/GE signed two's complement; SLTU/GEU unsigned. GE = !SLT, GEU = !SLTU.
- Shifts use i_op2[SHW-1:0] only; SRA replicates i_op1[XLEN-1].
- ADD/SUB wrap modulo 2^XLEN.
- MUL: low XLEN bits of product. MULH: high XLEN bits, signed×signed. MULHSU: signed i_op1 × unsigned i_op2. MULHU: unsigned×unsigned.
- DIV/REM: signed, quotient truncates toward zero, remainder takes dividend's sign. DIVU/REMU unsigned.
- Divide by zero: DIV/DIVU -> all ones; REM/REMU -> i_op1.
- Signed overflow (i_op1 = -2^(XLEN-1), i_op2 = -1): DIV -> i_op1, REM -> 0.
- Mul/div datapath: operands latched at acceptance, converted to magnitudes for signed variants, XLEN shift-add / restoring-subtract iterations with a 2*XLEN accumulator, then final sign correction and result selection.
- FSM states: IDLE, ITER, FIN.
  - IDLE: o_ready=1. Accepted base op -> result registered, stay IDLE. Accepted mul/div op -> load operands, counter=0, go ITER.
  - ITER: one iteration per cycle; counter increments; counter==XLEN-1 -> FIN.
  - FIN: sign-correct, register o_result, pulse o_valid -> IDLE.
- Special cases (div by zero, overflow) still run full iteration count; latency is operand-independent.
- i_flush: any state -> IDLE at next edge; aborted op never produces o_valid; o_result unchanged. i_flush with i_valid in the same cycle: flush wins, request not accepted.

## Timing
- Reset: state IDLE, o_ready=1, o_valid=0, o_result=0, counter=0.
- Reset asserted mid-operation: immediate return to reset values; no o_valid.
- Base op accepted at edge E0: o_valid=1 and o_result valid in the cycle after E0.
- Mul/div accepted at edge E0: o_ready=0 from E0 until edge E0+XLEN+1; o_valid=1 in the cycle after edge E0+XLEN+1 (latency XLEN+1 edges; 33 for XLEN=32).
- o_ready=1 in the same cycle o_valid pulses: back-to-back issue allowed, zero bubble.
- Base ops back-to-back: one result per cycle, o_valid held high continuously.
- Inputs i_op/i_op1/i_op2 are don't-care after acceptance.

## Test plan
- Reset mid-DIV (10 cycles in): o_valid never fires, o_ready=1, o_result=0 after release.
- Base ops back-to-back, XLEN=32: SUB 5,7 -> 0xFFFFFFFE; SLT 0xFFFFFFFF,1 -> 1; SLTU same -> 0; GE 0x80000000,1 -> 0; SRA 0x80000000,31 -> 0xFFFFFFFF; o_valid high every cycle.
- MULH 0xFFFFFFFF,0xFFFFFFFF -> 0; MULHU same -> 0xFFFFFFFE; MULHSU same -> 0xFFFFFFFF; MUL same -> 1; each o_valid exactly 33 edges after acceptance.
- DIV -7,2 -> 0xFFFFFFFD; REM -7,2 -> 0xFFFFFFFF; DIVU 7,0 -> 0xFFFFFFFF; REMU 7,0 -> 7; DIV 0x80000000,0xFFFFFFFF -> 0x80000000, REM -> 0.
- i_flush at ITER cycle 5, with i_valid asserted for ADD 1,2 in the flush cycle: no o_valid for either; ADD re-issued next cycle -> 3 one cycle later.
- XLEN=64: MULHU 2^63,4 -> 2; SLL 1,63 -> 0x8000000000000000; DIVU latency 65 edges.

Source files
------------

// File: rtl/asrv32_alu_md_if.sv
// asrv32 execute-stage ALU request/response bus.
// master = issuing pipeline stage, slave = ALU.
interface asrv32_alu_md_if #(
  parameter int XLEN = 32
);
  logic            i_valid;
  logic            o_ready;
  logic [4:0]      i_op;
  logic [XLEN-1:0] i_op1;
  logic [XLEN-1:0] i_op2;
  logic            i_flush;
  logic            o_valid;
  logic [XLEN-1:0] o_result;

  modport master (
    output i_valid, i_op, i_op1, i_op2, i_flush,
    input  o_ready, o_valid, o_result
  );

  modport slave (
    input  i_valid, i_op, i_op1, i_op2, i_flush,
    output o_ready, o_valid, o_result
  );
endinterface

// File: rtl/asrv32_alu_md.sv
// asrv32 registered execute-stage ALU with RV32I base ops and M-extension
// multiply/divide on a shared iterative radix-2 datapath.
// Base ops: result one edge after acceptance.
// Mul/div: result XLEN+1 edges after acceptance, independent of operand values.
module asrv32_alu_md #(
  parameter int XLEN = 32
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  asrv32_alu_md_if.slave bus
);
  localparam int SHW = $clog2(XLEN);

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLT    = 5'd2;
  localparam logic [4:0] OP_SLTU   = 5'd3;
  localparam logic [4:0] OP_XOR    = 5'd4;
  localparam logic [4:0] OP_OR     = 5'd5;
  localparam logic [4:0] OP_AND    = 5'd6;
  localparam logic [4:0] OP_SLL    = 5'd7;
  localparam logic [4:0] OP_SRL    = 5'd8;
  localparam logic [4:0] OP_SRA    = 5'd9;
  localparam logic [4:0] OP_EQ     = 5'd10;
  localparam logic [4:0] OP_NEQ    = 5'd11;
  localparam logic [4:0] OP_GE     = 5'd12;
  localparam logic [4:0] OP_GEU    = 5'd13;
  localparam logic [4:0] OP_MUL    = 5'd14;
  localparam logic [4:0] OP_MULH   = 5'd15;
  localparam logic [4:0] OP_MULHSU = 5'd16;
  localparam logic [4:0] OP_MULHU  = 5'd17;
  localparam logic [4:0] OP_DIV    = 5'd18;
  localparam logic [4:0] OP_DIVU   = 5'd19;
  localparam logic [4:0] OP_REM    = 5'd20;
  localparam logic [4:0] OP_REMU   = 5'd21;

  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // Single-cycle integer / compare / shift result; unassigned codes give 0.
  function automatic logic [XLEN-1:0] base_op(
    input logic [4:0]      op,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b
  );
    logic [XLEN-1:0] r;
    logic            lt;
    logic            ltu;
    lt  = $signed(a) < $signed(b);
    ltu = a < b;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_SLT:  r = {{(XLEN-1){1'b0}}, lt};
      OP_SLTU: r = {{(XLEN-1){1'b0}}, ltu};
      OP_XOR:  r = a ^ b;
      OP_OR:   r = a | b;
      OP_AND:  r = a & b;
      OP_SLL:  r = a << b[SHW-1:0];
      OP_SRL:  r = a >> b[SHW-1:0];
      OP_SRA:  r = $signed(a) >>> b[SHW-1:0];
      OP_EQ:   r = {{(XLEN-1){1'b0}}, (a == b)};
      OP_NEQ:  r = {{(XLEN-1){1'b0}}, (a != b)};
      OP_GE:   r = {{(XLEN-1){1'b0}}, ~lt};
      OP_GEU:  r = {{(XLEN-1){1'b0}}, ~ltu};
      default: r = ZERO;
    endcase
    return r;
  endfunction

  state_t            state_r, state_s;
  logic [SHW-1:0]    cnt_r, cnt_s;
  logic [2*XLEN-1:0] acc_r, acc_s;
  logic [XLEN-1:0]   mag_b_r, mag_b_s;
  logic [XLEN-1:0]   op1_r, op1_s;
  logic [4:0]        op_r, op_s;
  logic              neg_q_r, neg_q_s;
  logic              neg_rem_r, neg_rem_s;
  logic              dz_r, dz_s;
  logic              ovf_r, ovf_s;
  logic              valid_r, valid_s;
  logic [XLEN-1:0]   result_r, result_s;

  logic              ready_s;
  logic              accept_s;
  logic              is_md_s;
  logic              sgn_a_s, sgn_b_s;
  logic [XLEN-1:0]   mag_a_s, mag_bin_s;
  logic              is_mul_r_s;
  logic [XLEN:0]     mul_sum_s;
  logic [XLEN:0]     div_up_s;
  logic [XLEN:0]     div_diff_s;
  logic              div_ge_s;
  logic [2*XLEN-1:0] step_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s;
  logic [XLEN-1:0]   fin_s;

  assign ready_s  = (state_r == ST_IDLE);
  assign accept_s = bus.i_valid & ready_s & ~bus.i_flush;
  assign is_md_s  = (bus.i_op >= OP_MUL) && (bus.i_op <= OP_REMU);

  // Decide operand signedness at acceptance and form magnitudes.
  always_comb begin
    sgn_a_s = 1'b0;
    sgn_b_s = 1'b0;
    case (bus.i_op)
      OP_MULH, OP_DIV, OP_REM: begin
        sgn_a_s = bus.i_op1[XLEN-1];
        sgn_b_s = bus.i_op2[XLEN-1];
      end
      OP_MULHSU: begin
        sgn_a_s = bus.i_op1[XLEN-1];
        sgn_b_s = 1'b0;
      end
      default: begin
        sgn_a_s = 1'b0;
        sgn_b_s = 1'b0;
      end
    endcase
    mag_a_s   = sgn_a_s ? (-bus.i_op1) : bus.i_op1;
    mag_bin_s = sgn_b_s ? (-bus.i_op2) : bus.i_op2;
  end

  // One radix-2 step: shift-add for multiply, restoring subtract for divide.
  // Multiply: acc = {partial_high, multiplier}, shifting right each step.
  // Divide:   acc = {remainder, dividend/quotient}, shifting left each step.
  always_comb begin
    is_mul_r_s = (op_r <= OP_MULHU);
    mul_sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} +
                 (acc_r[0] ? {1'b0, mag_b_r} : {(XLEN+1){1'b0}});
    div_up_s   = acc_r[2*XLEN-1:XLEN-1];
    div_ge_s   = (div_up_s >= {1'b0, mag_b_r});
    div_diff_s = div_up_s - {1'b0, mag_b_r};
    if (is_mul_r_s) begin
      step_s = {mul_sum_s, acc_r[XLEN-1:1]};
    end else begin
      step_s = {(div_ge_s ? div_diff_s[XLEN-1:0] : div_up_s[XLEN-1:0]),
                acc_r[XLEN-2:0], div_ge_s};
    end
  end

  // Sign correction and result selection after the last iteration.
  always_comb begin
    prod_s = neg_q_r ? (-acc_r) : acc_r;
    quo_s  = neg_q_r ? (-acc_r[XLEN-1:0]) : acc_r[XLEN-1:0];
    rem_s  = neg_rem_r ? (-acc_r[2*XLEN-1:XLEN]) : acc_r[2*XLEN-1:XLEN];
    case (op_r)
      OP_MUL:                        fin_s = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fin_s = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU: begin
        if (dz_r) begin
          fin_s = ALL_ONES;
        end else if (ovf_r) begin
          fin_s = op1_r;
        end else begin
          fin_s = quo_s;
        end
      end
      OP_REM, OP_REMU: begin
        if (dz_r) begin
          fin_s = op1_r;
        end else if (ovf_r) begin
          fin_s = ZERO;
        end else begin
          fin_s = rem_s;
        end
      end
      default: fin_s = ZERO;
    endcase
  end

  // Next-state and datapath control: IDLE accepts, ITER steps, FIN publishes.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    acc_s     = acc_r;
    mag_b_s   = mag_b_r;
    op1_s     = op1_r;
    op_s      = op_r;
    neg_q_s   = neg_q_r;
    neg_rem_s = neg_rem_r;
    dz_s      = dz_r;
    ovf_s     = ovf_r;
    valid_s   = 1'b0;
    result_s  = result_r;
    if (bus.i_flush) begin
      // Abort whatever is in flight; o_result keeps its last value.
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s && is_md_s) begin
            op_s      = bus.i_op;
            op1_s     = bus.i_op1;
            acc_s     = {ZERO, mag_a_s};
            mag_b_s   = mag_bin_s;
            neg_q_s   = sgn_a_s ^ sgn_b_s;
            neg_rem_s = sgn_a_s;
            dz_s      = (bus.i_op2 == ZERO);
            ovf_s     = ((bus.i_op == OP_DIV) || (bus.i_op == OP_REM)) &&
                        (bus.i_op1 == MIN_NEG) && (bus.i_op2 == ALL_ONES);
            cnt_s     = {SHW{1'b0}};
            state_s   = ST_ITER;
          end else if (accept_s) begin
            result_s = base_op(bus.i_op, bus.i_op1, bus.i_op2);
            valid_s  = 1'b1;
            state_s  = ST_IDLE;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_ITER: begin
          acc_s = step_s;
          cnt_s = cnt_r + SHW'(1);
          if (cnt_r == SHW'(XLEN-1)) begin
            state_s = ST_FIN;
          end else begin
            state_s = ST_ITER;
          end
        end
        ST_FIN: begin
          result_s = fin_s;
          valid_s  = 1'b1;
          state_s  = ST_IDLE;
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {SHW{1'b0}};
      acc_r     <= {(2*XLEN){1'b0}};
      mag_b_r   <= ZERO;
      op1_r     <= ZERO;
      op_r      <= 5'd0;
      neg_q_r   <= 1'b0;
      neg_rem_r <= 1'b0;
      dz_r      <= 1'b0;
      ovf_r     <= 1'b0;
      valid_r   <= 1'b0;
      result_r  <= ZERO;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      acc_r     <= acc_s;
      mag_b_r   <= mag_b_s;
      op1_r     <= op1_s;
      op_r      <= op_s;
      neg_q_r   <= neg_q_s;
      neg_rem_r <= neg_rem_s;
      dz_r      <= dz_s;
      ovf_r     <= ovf_s;
      valid_r   <= valid_s;
      result_r  <= result_s;
    end
  end

  assign bus.o_ready  = ready_s;
  assign bus.o_valid  = valid_r;
  assign bus.o_result = result_r;

endmodule
